// File: rtl/seven_seg_pkg.sv
// Shared constants for the 3-digit seven-segment scanner: glyph codes, segment-off pattern, phase encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seven_seg_pkg;

    localparam logic [4:0] GLYPH_BLANK      = 5'h12;
    localparam logic [4:0] GLYPH_RIGHT_ONE  = 5'h01;
    localparam logic [4:0] GLYPH_LEFT_ONE   = 5'h16;
    localparam logic [4:0] GLYPH_DOUBLE_EL  = 5'h17;
    localparam logic [4:0] GLYPH_DASH       = 5'h10;
    localparam logic [4:0] GLYPH_UNDERSCORE = 5'h11;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [0:0] PH_BLANK = 1'b0;
    localparam logic [0:0] PH_SHOW  = 1'b1;

endpackage

// File: rtl/seven_seg_decoder.sv
// Glyph code to active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is always off.
// Latency: combinational.
// Backpressure: none.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [4:0] code,
    output logic [7:0] seg
);

    // Active-high {g,f,e,d,c,b,a}; inverted onto the active-low output below.
    logic [6:0] lit;

    always_comb begin
        lit = 7'h00;
        case (code)
            5'h00:            lit = 7'h3F;
            5'h01:            lit = 7'h06;
            5'h02:            lit = 7'h5B;
            5'h03:            lit = 7'h4F;
            5'h04:            lit = 7'h66;
            5'h05:            lit = 7'h6D;
            5'h06:            lit = 7'h7D;
            5'h07:            lit = 7'h07;
            5'h08:            lit = 7'h7F;
            5'h09:            lit = 7'h6F;
            5'h0A:            lit = 7'h77;
            5'h0B:            lit = 7'h7C;
            5'h0C:            lit = 7'h39;
            5'h0D:            lit = 7'h5E;
            5'h0E:            lit = 7'h79;
            5'h0F:            lit = 7'h71;
            GLYPH_DASH:       lit = 7'h40;
            GLYPH_UNDERSCORE: lit = 7'h08;
            GLYPH_LEFT_ONE:   lit = 7'h30;
            GLYPH_DOUBLE_EL:  lit = 7'h36;
            default:          lit = 7'h00;
        endcase
    end

    assign seg = {1'b1, ~lit};

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 3-digit seven-segment scanner: BLANK then SHOW per digit, left to right; SEVEN_SEG_DIM_EN adds bright PWM.
// Latency: seg/an/frame_tick registered, change on the same edge as the phase register.
// Backpressure: none; free-running scan, glyph and brightness sampled on SHOW entry.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int SHOW_LOG2    = 12,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] hex2,
    input  logic [4:0] hex1,
    input  logic [4:0] hex0,
`ifdef SEVEN_SEG_DIM_EN
    input  logic [2:0] bright,
`endif
    output logic [7:0] seg,
    output logic [2:0] an,
    output logic       frame_tick
);

    // One counter serves both phases, so it must be wide enough for either.
    localparam int CW = (SHOW_LOG2 > 8) ? SHOW_LOG2 : 8;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'((1 << SHOW_LOG2) - 1);

    logic [0:0]    phase, phase_n;
    logic [1:0]    digit, digit_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    glyph, glyph_n, hex_sel;
    logic [7:0]    dec_seg;
    logic          entering;
    logic          lit_n;

    always_comb begin
        case (digit)
            2'd2:    hex_sel = hex2;
            2'd1:    hex_sel = hex1;
            default: hex_sel = hex0;
        endcase
    end

    always_comb begin
        phase_n = phase;
        digit_n = digit;
        cnt_n   = cnt + CNT_ONE;
        if (phase == PH_BLANK) begin
            if (cnt == BLANK_LAST) begin
                phase_n = PH_SHOW;
                cnt_n   = '0;
            end
        end else if (cnt == SHOW_LAST) begin
            phase_n = PH_BLANK;
            cnt_n   = '0;
            digit_n = (digit == 2'd0) ? 2'd2 : digit - 2'd1;
        end
    end

    assign entering = (phase == PH_BLANK) && (cnt == BLANK_LAST);
    assign glyph_n  = entering ? hex_sel : glyph;

`ifdef SEVEN_SEG_DIM_EN
    logic [2:0] bright_q, bright_n;

    assign bright_n = entering ? bright : bright_q;
    // PWM phase is the top three bits of the SHOW counter; lit while it has not passed bright.
    assign lit_n    = (phase_n == PH_SHOW) && (cnt_n[SHOW_LOG2-1 -: 3] <= bright_n);

    always_ff @(posedge clk) begin
        if (reset) begin
            bright_q <= 3'd7;
        end else begin
            bright_q <= bright_n;
        end
    end
`else
    assign lit_n = (phase_n == PH_SHOW);
`endif

    seven_seg_decoder u_decoder (
        .code (glyph_n),
        .seg  (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= PH_BLANK;
            digit      <= 2'd2;
            cnt        <= '0;
            glyph      <= GLYPH_BLANK;
            seg        <= SEG_OFF;
            an         <= 3'b111;
            frame_tick <= 1'b0;
        end else begin
            phase      <= phase_n;
            digit      <= digit_n;
            cnt        <= cnt_n;
            glyph      <= glyph_n;
            seg        <= lit_n ? dec_seg : SEG_OFF;
            an         <= lit_n ? ~(3'b001 << digit_n) : 3'b111;
            frame_tick <= (phase_n == PH_SHOW) && (digit_n == 2'd0) && (cnt_n == SHOW_LAST);
        end
    end

endmodule
